// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - 9-bit word FIFO feeding a UART transmitter through a launch handshake FSM.
// Optional flush port and logic are built only when UART_TXQ_FLUSH_EN is defined.
module uart_tx_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [8:0]               wr_data,
    output logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     uart_ready,
    input  logic                     uart_busy,
    output logic                     uart_start,
    output logic [8:0]               uart_data
`ifdef UART_TXQ_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]  uart_data_q, uart_data_d;
    logic        uart_start_q, uart_start_d;
    logic [8:0]  mem_q [DEPTH];
    logic        wr_fire;
    logic        launch;

    // Pointers carry one extra bit so full (DEPTH) and empty (0) differ.
    assign level = wr_ptr_q - rd_ptr_q;

`ifdef UART_TXQ_FLUSH_EN
    assign wr_ready = (level != FULL_LEVEL) && !flush;
`else
    assign wr_ready = (level != FULL_LEVEL);
`endif

    assign wr_fire    = wr_valid && wr_ready;
    assign uart_start = uart_start_q;
    assign uart_data  = uart_data_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_fire ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        uart_data_d  = uart_data_q;
        uart_start_d = 1'b0;
        launch       = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef UART_TXQ_FLUSH_EN
                launch = (level != '0) && uart_ready && !flush;
`else
                launch = (level != '0) && uart_ready;
`endif
                if (launch) begin
                    uart_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                    uart_start_d = 1'b1;
                    rd_ptr_d     = rd_ptr_q + PTR_ONE;
                    state_d      = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (uart_ready && !uart_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_TXQ_FLUSH_EN
        // Flush empties the queue but leaves an already launched frame to finish.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            uart_data_q  <= 9'h000;
            uart_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            uart_data_q  <= uart_data_d;
            uart_start_q <= uart_start_d;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue (DEPTH 16).
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [8:0] wr_data = 9'h000;
    logic       wr_ready;
    logic [4:0] level;
    logic       uart_ready;
    logic       uart_busy;
    logic       uart_start;
    logic [8:0] uart_data;
`ifdef UART_TXQ_FLUSH_EN
    logic       flush = 1'b0;
`endif

    logic d_ready = 1'b0;
    logic d_busy  = 1'b0;
    logic m_ready = 1'b1;
    logic m_busy  = 1'b0;
    logic model_en = 1'b0;
    int   busy_len = 2;
    int   m_cnt = 0;

    assign uart_ready = model_en ? m_ready : d_ready;
    assign uart_busy  = model_en ? m_busy  : d_busy;

    int total = 0;
    int bad   = 0;

    int         cyc = 0;
    int         start_cnt = 0;
    int         viol = 0;
    logic       blocked_prev = 1'b1;
    logic [8:0] cap   [256];
    int         cap_t [256];

    uart_tx_queue #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .level      (level),
        .uart_ready (uart_ready),
        .uart_busy  (uart_busy),
        .uart_start (uart_start),
        .uart_data  (uart_data)
`ifdef UART_TXQ_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Launch monitor: a start must follow a cycle with ready high and busy low.
    always @(negedge clk) begin
        if (uart_start) begin
            if (blocked_prev) viol++;
            cap[start_cnt[7:0]]   = uart_data;
            cap_t[start_cnt[7:0]] = cyc;
            start_cnt++;
        end
        blocked_prev = !uart_ready || uart_busy;
    end

    // Transmitter model: busy for busy_len cycles after each start.
    always @(posedge clk) begin
        #1;
        if (model_en) begin
            if (uart_start) begin
                m_ready = 1'b0;
                m_busy  = 1'b1;
                m_cnt   = busy_len;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy  = 1'b0;
                    m_ready = 1'b1;
                end
            end
        end else begin
            m_ready = 1'b1;
            m_busy  = 1'b0;
            m_cnt   = 0;
        end
    end

    typedef struct packed {
        logic       wv;
        logic [8:0] wd;
        logic       ur;
        logic       ub;
        logic       e_rdy;
        logic [4:0] e_lvl;
        logic       e_st;
        logic [8:0] e_dat;
    } vec_t;

    vec_t vt [13];

    function automatic vec_t mk(input logic wv, input logic [8:0] wd, input logic ur,
                                input logic ub, input logic e_rdy, input logic [4:0] e_lvl,
                                input logic e_st, input logic [8:0] e_dat);
        vec_t v;
        v.wv = wv; v.wd = wd; v.ur = ur; v.ub = ub;
        v.e_rdy = e_rdy; v.e_lvl = e_lvl; v.e_st = e_st; v.e_dat = e_dat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        model_en = 1'b0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        d_ready  = 1'b0;
        d_busy   = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic push(input logic [8:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick;
        wr_valid = 1'b0;
    endtask

    task automatic wait_starts(input string name, input int base, input int n, input int limit);
        int c = 0;
        while (start_cnt < base + n && c < limit) begin
            tick;
            c++;
        end
        check(name, 32'(start_cnt - base), 32'(n));
    endtask

    initial begin
        int base;
        int v0;

        vt[0]  = mk(1'b1, 9'h055, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 9'h000);
        vt[1]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 9'h055);
        vt[2]  = mk(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 9'h055);
        vt[3]  = mk(1'b1, 9'h1AA, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 9'h055);
        vt[4]  = mk(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 9'h055);
        vt[5]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 9'h055);
        vt[6]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 9'h1AA);
        vt[7]  = mk(1'b1, 9'h0F0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 9'h1AA);
        vt[8]  = mk(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 9'h1AA);
        vt[9]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 9'h1AA);
        vt[10] = mk(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 9'h0F0);
        vt[11] = mk(1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 9'h0F0);
        vt[12] = mk(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 9'h0F0);

        // Reset state while rst is held
        tick;
        check("rst_level", 32'(level), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_start", 32'(uart_start), 32'd0);
        check("rst_data", 32'(uart_data), 32'h000);
        rst = 1'b0;
        tick;

        // Single-word launch and handshake walk
        for (int i = 0; i < 13; i++) begin
            wr_valid = vt[i].wv;
            wr_data  = vt[i].wd;
            d_ready  = vt[i].ur;
            d_busy   = vt[i].ub;
            tick;
            check($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vt[i].e_rdy));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].e_lvl));
            check($sformatf("vec%0d_start", i), 32'(uart_start), 32'(vt[i].e_st));
            check($sformatf("vec%0d_data", i), 32'(uart_data), 32'(vt[i].e_dat));
        end
        wr_valid = 1'b0;

        // Fill to full, refuse 17th, drain in order
        do_reset;
        for (int i = 0; i < 16; i++) push(9'h100 + 9'(i));
        check("full_level", 32'(level), 32'd16);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        push(9'h1FF);
        check("full_refuse_level", 32'(level), 32'd16);
        busy_len = 2;
        base = start_cnt;
        model_en = 1'b1;
        wait_starts("full_drain_count", base, 16, 400);
        for (int i = 0; i < 16; i++)
            check($sformatf("full_order%0d", i), 32'(cap[8'(base + i)]), 32'(9'h100 + 9'(i)));
        tick;
        check("full_drain_level", 32'(level), 32'd0);

        // Full queue: write and launch pop in the same cycle
        do_reset;
        for (int i = 0; i < 16; i++) push(9'h100 + 9'(i));
        wr_valid = 1'b1;
        wr_data  = 9'h1EE;
        d_ready  = 1'b1;
        tick;
        wr_valid = 1'b0;
        d_ready  = 1'b0;
        check("fullpop_level", 32'(level), 32'd15);
        check("fullpop_start", 32'(uart_start), 32'd1);
        check("fullpop_data", 32'(uart_data), 32'h100);
        check("fullpop_wr_ready", 32'(wr_ready), 32'd1);
        d_busy = 1'b1;
        tick;
        d_busy  = 1'b0;
        d_ready = 1'b1;
        tick;
        base = start_cnt;
        model_en = 1'b1;
        wait_starts("fullpop_drain_count", base, 15, 400);
        for (int i = 0; i < 15; i++)
            check($sformatf("fullpop_order%0d", i), 32'(cap[8'(base + i)]), 32'(9'h101 + 9'(i)));

        // Half full: write plus pop keeps level
        do_reset;
        for (int i = 0; i < 8; i++) push(9'h040 + 9'(i));
        wr_valid = 1'b1;
        wr_data  = 9'h1C3;
        d_ready  = 1'b1;
        tick;
        wr_valid = 1'b0;
        d_ready  = 1'b0;
        check("half_level", 32'(level), 32'd8);
        check("half_start", 32'(uart_start), 32'd1);
        check("half_data", 32'(uart_data), 32'h040);
        d_busy = 1'b1;
        tick;
        d_busy  = 1'b0;
        d_ready = 1'b1;
        tick;
        base = start_cnt;
        model_en = 1'b1;
        wait_starts("half_drain_count", base, 8, 300);
        for (int i = 0; i < 7; i++)
            check($sformatf("half_order%0d", i), 32'(cap[8'(base + i)]), 32'(9'h041 + 9'(i)));
        check("half_order7", 32'(cap[8'(base + 7)]), 32'h1C3);

        // Transmitter with 10-cycle busy, three words
        do_reset;
        push(9'h011);
        push(9'h022);
        push(9'h033);
        busy_len = 10;
        base = start_cnt;
        v0 = viol;
        model_en = 1'b1;
        wait_starts("busy_count", base, 3, 200);
        repeat (30) tick;
        check("busy_count_after", 32'(start_cnt - base), 32'd3);
        check("busy_violations", 32'(viol - v0), 32'd0);
        check("busy_w0", 32'(cap[8'(base)]), 32'h011);
        check("busy_w1", 32'(cap[8'(base + 1)]), 32'h022);
        check("busy_w2", 32'(cap[8'(base + 2)]), 32'h033);
        check("busy_gap1", 32'(cap_t[8'(base + 1)] - cap_t[8'(base)] >= 12), 32'd1);
        check("busy_gap2", 32'(cap_t[8'(base + 2)] - cap_t[8'(base + 1)] >= 12), 32'd1);

        // Async reset during WAIT_DONE with four words queued
        do_reset;
        for (int i = 0; i < 5; i++) push(9'h0B0 + 9'(i));
        d_ready = 1'b1;
        tick;
        d_ready = 1'b0;
        d_busy  = 1'b1;
        tick;
        check("midrst_pre_level", 32'(level), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_start", 32'(uart_start), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_data", 32'(uart_data), 32'h000);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        tick;
        rst    = 1'b0;
        d_busy = 1'b0;
        repeat (3) tick;
        check("midrst_idle_start", 32'(uart_start), 32'd0);
        push(9'h0C1);
        repeat (2) tick;
        check("midrst_hold_start", 32'(uart_start), 32'd0);
        check("midrst_hold_level", 32'(level), 32'd1);
        d_ready = 1'b1;
        tick;
        d_ready = 1'b0;
        check("midrst_launch_start", 32'(uart_start), 32'd1);
        check("midrst_launch_data", 32'(uart_data), 32'h0C1);
        check("midrst_launch_level", 32'(level), 32'd0);

`ifdef UART_TXQ_FLUSH_EN
        // Flush with one frame in flight
        do_reset;
        for (int i = 0; i < 5; i++) push(9'h0D0 + 9'(i));
        d_ready = 1'b1;
        tick;
        check("flush_launch_data", 32'(uart_data), 32'h0D0);
        d_ready  = 1'b0;
        d_busy   = 1'b1;
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 9'h1D1;
        #1;
        check("flush_wr_ready", 32'(wr_ready), 32'd0);
        tick;
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        base = start_cnt;
        d_busy  = 1'b0;
        d_ready = 1'b1;
        repeat (6) tick;
        check("flush_no_start", 32'(start_cnt - base), 32'd0);
        check("flush_level_end", 32'(level), 32'd0);
        push(9'h0E7);
        tick;
        check("flush_resume_data", 32'(uart_data), 32'h0E7);
        d_ready = 1'b0;
`endif

        check("global_violations", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
